// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch front-end types and widths: bus widths, the FIFO entry layout,
// the counter-derived fetch state and a PC alignment helper.
package instr_fetch_queue_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    localparam int IMEM_ADDR_W  = ADDR_W;
    localparam int IMEM_DATA_W  = INSTR_W;
    localparam int FIFO_DATA_W  = INSTR_W + ADDR_W;

    typedef enum logic [1:0] {
        FQ_FETCH,
        FQ_HOLD,
        FQ_DRAIN
    } fq_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fq_entry_t;

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return pc & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch queue signal bundle: redirect, instruction memory req/gnt/rvalid and the
// decode-side valid/ready handshake. master is the fetch queue, slave its environment.
interface instr_fetch_queue_if;
    import instr_fetch_queue_pkg::*;

    logic                   redirect_i;
    logic [ADDR_W-1:0]      redirect_pc_i;
    logic                   imem_req_o;
    logic [IMEM_ADDR_W-1:0] imem_addr_o;
    logic                   imem_gnt_i;
    logic                   imem_rvalid_i;
    logic [IMEM_DATA_W-1:0] imem_rdata_i;
    logic                   instr_valid_o;
    logic [INSTR_W-1:0]     instr_o;
    logic [ADDR_W-1:0]      instr_pc_o;
    logic [ADDR_W-1:0]      instr_pc4_o;
    logic                   instr_ready_i;

    modport master (
        input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
               instr_ready_i,
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_pc4_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
               instr_ready_i,
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, instr_pc4_o
    );

endinterface

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Synchronous FIFO with a flush input; full/empty come from pointers carrying a wrap bit.
module fetch_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              full;
    logic              do_wr;
    logic              do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A write at full is accepted only when the head leaves in the same cycle.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues credit-limited in-order imem requests,
// queues returned words with their PC and discards in-flight responses after a redirect.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    instr_fetch_queue_if.master   fq
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstanding_next;
    logic [CNT_W-1:0]  discard;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    in_use;
    logic              credit;
    logic              req;
    logic              grant;
    logic              keep;
    logic              drop;
    logic              fifo_empty;
    logic              instr_valid;
    logic              consume;
    fq_entry_t         wr_entry;
    fq_entry_t         head;
    fq_state_e         state;

    // Queued words plus in-flight requests never exceed DEPTH, so every response has a slot.
    assign in_use = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(outstanding);
    assign credit = in_use < (CNT_W + 1)'(DEPTH);

    always_comb begin
        state = FQ_FETCH;
        if (!credit) begin
            state = FQ_HOLD;
        end else if (discard != '0) begin
            state = FQ_DRAIN;
        end
    end

    assign req   = !rst_i && !fq.redirect_i && (state != FQ_HOLD);
    assign grant = req && fq.imem_gnt_i;
    assign drop  = fq.imem_rvalid_i && (discard != '0);
    assign keep  = fq.imem_rvalid_i && (discard == '0) && !fq.redirect_i;

    assign outstanding_next = outstanding + CNT_W'(grant) - CNT_W'(fq.imem_rvalid_i);

    assign fq.imem_req_o  = req;
    assign fq.imem_addr_o = fetch_pc;

    // After a redirect every request still in flight belongs to the old path, so the
    // discard count becomes the post-edge outstanding count; this also covers back-to-back redirects.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (fq.redirect_i) begin
                fetch_pc <= align_pc(fq.redirect_pc_i);
                rsp_pc   <= align_pc(fq.redirect_pc_i);
                discard  <= outstanding_next;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end
                if (keep) begin
                    rsp_pc <= rsp_pc + ADDR_W'(4);
                end
                if (drop) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

    assign wr_entry.instr = fq.imem_rdata_i;
    assign wr_entry.pc    = rsp_pc;

    fetch_fifo #(
        .DATA_W (FIFO_DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .flush   (fq.redirect_i),
        .wr_en   (keep),
        .wr_data (wr_entry),
        .rd_en   (consume),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // The head is masked during reset so decode never sees a word from the aborted stream.
    assign instr_valid = !rst_i && !fifo_empty;
    assign consume     = instr_valid && fq.instr_ready_i;

    assign fq.instr_valid_o = instr_valid;
    assign fq.instr_o       = head.instr;
    assign fq.instr_pc_o    = head.pc;
    assign fq.instr_pc4_o   = head.pc + ADDR_W'(4);

    a_rvalid_has_request: assert property (
        @(posedge clk_i) disable iff (rst_i) !(fq.imem_rvalid_i && (outstanding == '0))
    );

endmodule
